// File: rtl/pix_capture_pkg.sv
// Shared types and helpers for the pixel-capture front end.
// keep_pix works on zero-extended counters of up to CNT_MAX_W bits.
package pix_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    STOPPING
  } cap_state_t;

  localparam int unsigned CNT_MAX_W = 32;
  localparam int unsigned K_MAX_W   = 8;

  // Pixel survives decimation when both quad indices are multiples of 2^k.
  function automatic logic keep_pix(input logic [CNT_MAX_W-1:0] x,
                                    input logic [CNT_MAX_W-1:0] y,
                                    input logic [K_MAX_W-1:0]   k);
    logic [CNT_MAX_W-1:0] mask;
    mask = ~({CNT_MAX_W{1'b1}} << k);
    return (((x >> 1) & mask) == '0) && (((y >> 1) & mask) == '0);
  endfunction

endpackage

// File: rtl/pix_edge_det.sv
// Registers a sensor strobe and flags its rising/falling edges against the
// previous registered value.
module pix_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_q_d,
  output logic o_rise,
  output logic o_fall
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_q   <= 1'b0;
      o_q_d <= 1'b0;
    end else begin
      o_q   <= i_d;
      o_q_d <= o_q;
    end
  end

  assign o_rise = o_q & ~o_q_d;
  assign o_fall = ~o_q & o_q_d;

endmodule

// File: rtl/pix_capture.sv
// Sensor pixel-capture front end: frame-aligned start/stop, raw X/Y, frame count,
// SOF/EOL markers. Decimation is built only when PIX_CAPTURE_DECIM_EN is defined.
module pix_capture
  import pix_capture_pkg::*;
#(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned X_W     = 16,
  parameter int unsigned Y_W     = 16,
  parameter int unsigned FRAME_W = 32,
  parameter int unsigned SKIP_W  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_fval,
  input  logic               i_lval,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SKIP_W-1:0]  i_skip_log2,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_valid,
  output logic [X_W-1:0]     o_x,
  output logic [Y_W-1:0]     o_y,
  output logic               o_sof,
  output logic               o_eol,
  output logic [FRAME_W-1:0] o_frame_cnt,
  output logic               o_active
);

  cap_state_t        state, state_nx;
  logic              fval_r, fval_q, fval_rise, fval_fall;
  logic              lval_r, lval_q, lval_rise, lval_fall;
  logic [DATA_W-1:0] data_r;
  logic [X_W-1:0]    x_cnt, x_cur;
  logic [Y_W-1:0]    y_cnt, y_cur;
  logic              seen_low, row_kept, sof_pend;
  logic              act, sof_edge, pix, keep, line_end;

  pix_edge_det u_fval (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_fval),
    .o_q(fval_r), .o_q_d(fval_q), .o_rise(fval_rise), .o_fall(fval_fall)
  );

  pix_edge_det u_lval (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_lval),
    .o_q(lval_r), .o_q_d(lval_q), .o_rise(lval_rise), .o_fall(lval_fall)
  );

  logic unused_sig;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) data_r <= '0;
    else          data_r <= i_data;
  end

  assign act      = (state == CAPTURE) || (state == STOPPING);
  // Frame start needs an fval low seen while armed, so a frame already running
  // at arm time (or at reset release) is never picked up part-way.
  assign sof_edge = fval_rise && ((state == CAPTURE) || ((state == ARMED) && seen_low));
  assign x_cur    = sof_edge ? '0 : x_cnt;
  assign y_cur    = sof_edge ? '0 : y_cnt;
  assign pix      = ((act && fval_r) || sof_edge) && lval_r;
  // fval dropping while lval is still high also closes the line.
  assign line_end = act && fval_q && (lval_fall || (fval_fall && lval_q));

`ifdef PIX_CAPTURE_DECIM_EN
  logic [SKIP_W-1:0] k_q, k_cur;

  assign k_cur = sof_edge ? i_skip_log2 : k_q;
  assign keep  = pix && keep_pix(CNT_MAX_W'(x_cur), CNT_MAX_W'(y_cur), K_MAX_W'(k_cur));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)      k_q <= '0;
    else if (sof_edge) k_q <= i_skip_log2;
  end

  assign unused_sig = lval_rise;
`else
  assign keep       = pix;
  assign unused_sig = lval_rise ^ (^i_skip_log2);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (i_start && !i_stop) state_nx = ARMED;
      ARMED:    if (i_stop) state_nx = IDLE;
                else if (sof_edge) state_nx = CAPTURE;
      CAPTURE:  if (i_stop) state_nx = fval_r ? STOPPING : IDLE;
      STOPPING: if (!fval_r) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      seen_low    <= 1'b0;
      row_kept    <= 1'b0;
      sof_pend    <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      seen_low <= (state == ARMED) && (seen_low || !fval_r);

      if (sof_edge) begin
        x_cnt <= lval_r ? X_W'(1) : '0;
        y_cnt <= '0;
      end else if (line_end) begin
        x_cnt <= '0;
        if (y_cnt != '1) y_cnt <= y_cnt + Y_W'(1);
      end else if (pix && x_cnt != '1) begin
        x_cnt <= x_cnt + X_W'(1);
      end

      if (state == IDLE)  row_kept <= 1'b0;
      else if (keep)      row_kept <= 1'b1;
      else if (line_end)  row_kept <= 1'b0;

      if (state == IDLE)  sof_pend <= 1'b0;
      else if (sof_edge)  sof_pend <= !keep;
      else if (keep)      sof_pend <= 1'b0;

      if (act && fval_fall) o_frame_cnt <= o_frame_cnt + FRAME_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
    end else begin
      o_data  <= data_r;
      o_valid <= keep;
      o_x     <= x_cur;
      o_y     <= y_cur;
      o_sof   <= keep && (sof_edge || sof_pend);
      o_eol   <= line_end && row_kept;
    end
  end

  assign o_active = act;

endmodule

// File: tb/tb_pix_capture.sv
// Directed bench for pix_capture using synthetic 8x4 frames.
module tb_pix_capture;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_start, i_stop, i_fval, i_lval;
  logic [11:0] i_data;
  logic [1:0]  i_skip_log2;
  logic [11:0] o_data;
  logic        o_valid, o_sof, o_eol, o_active;
  logic [15:0] o_x, o_y;
  logic [31:0] o_frame_cnt;

  int errs   = 0;
  int checks = 0;
  int dec;

  int          vcnt = 0, eolcnt = 0, sofcnt = 0;
  logic [27:0] px_q[$];
  logic [15:0] sof_pos = '0;

  pix_capture #(.DATA_W(12), .X_W(16), .Y_W(16), .FRAME_W(32), .SKIP_W(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
    .i_fval(i_fval), .i_lval(i_lval), .i_data(i_data), .i_skip_log2(i_skip_log2),
    .o_data(o_data), .o_valid(o_valid), .o_x(o_x), .o_y(o_y), .o_sof(o_sof),
    .o_eol(o_eol), .o_frame_cnt(o_frame_cnt), .o_active(o_active)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_valid) begin
      vcnt <= vcnt + 1;
      px_q.push_back({o_x[7:0], o_y[7:0], o_data});
    end
    if (o_eol) eolcnt <= eolcnt + 1;
    if (o_sof) begin
      sofcnt  <= sofcnt + 1;
      sof_pos <= {o_x[7:0], o_y[7:0]};
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {16'h0, o_data, o_x, o_y, o_sof, o_eol, o_valid, o_active}, 64'h0);
    chk({tag, "_fcnt"}, 64'(o_frame_cnt), 64'h0);
  endtask

  task automatic send_frame(input int tag, input int stop_line, input int start_line,
                            input int rst_line);
    i_fval = 1'b1;
    i_lval = 1'b0;
    tick; tick;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        i_lval  = 1'b1;
        i_data  = 12'(tag * 64 + y * 8 + x);
        i_stop  = (y == stop_line) && (x == 3);
        i_start = (y == start_line) && (x == 3);
        i_rst_n = !((y == rst_line) && (x == 3));
        tick;
        if ((y == rst_line) && (x == 3)) chk_outs_zero("rst_mid_line");
      end
      i_lval = 1'b0; i_stop = 1'b0; i_start = 1'b0; i_rst_n = 1'b1;
      tick; tick; tick;
    end
    i_fval = 1'b0;
    repeat (4) tick;
  endtask

  task automatic chk_frame(input int tag, input int decim, input int v0, input int e0,
                           input int s0);
    int          n;
    int          rows;
    logic [27:0] exp;
    n = 0;
    rows = 0;
    for (int y = 0; y < 4; y++) begin
      if (decim == 0 || (y % 4) < 2) rows++;
      for (int x = 0; x < 8; x++) begin
        if (decim == 0 || ((x % 4) < 2 && (y % 4) < 2)) begin
          exp = {8'(x), 8'(y), 12'(tag * 64 + y * 8 + x)};
          if (v0 + n < px_q.size()) chk($sformatf("pix_t%0d_n%0d", tag, n), 64'(px_q[v0 + n]), 64'(exp));
          n++;
        end
      end
    end
    chk($sformatf("vcnt_t%0d", tag), 64'(vcnt - v0), 64'(n));
    chk($sformatf("eol_t%0d", tag), 64'(eolcnt - e0), 64'(rows));
    chk($sformatf("sof_t%0d", tag), 64'(sofcnt - s0), 64'd1);
    chk($sformatf("sofpos_t%0d", tag), 64'(sof_pos), 64'h0);
  endtask

  initial begin
    int v0, e0, s0;
`ifdef PIX_CAPTURE_DECIM_EN
    dec = 1;
`else
    dec = 0;
`endif
    i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    i_fval = 1'b0; i_lval = 1'b0; i_data = '0; i_skip_log2 = '0;
    repeat (3) tick;
    chk_outs_zero("reset");
    i_rst_n = 1'b1;
    tick;

    // Frame 1, k=0.
    i_start = 1'b1; tick; i_start = 1'b0;
    repeat (3) tick;
    chk("active_armed", 64'(o_active), 64'd0);
    v0 = vcnt; e0 = eolcnt; s0 = sofcnt;
    send_frame(1, -1, -1, -1);
    chk_frame(1, 0, v0, e0, s0);
    chk("fcnt_f1", 64'(o_frame_cnt), 64'd1);
    chk("active_f1", 64'(o_active), 64'd1);

    // Frame 2, k=1.
    i_skip_log2 = 2'd1;
    v0 = vcnt; e0 = eolcnt; s0 = sofcnt;
    send_frame(2, -1, -1, -1);
    chk_frame(2, dec, v0, e0, s0);
    chk("fcnt_f2", 64'(o_frame_cnt), 64'd2);

    // Frame 3 with stop during line 2, then frame 4 ignored.
    i_skip_log2 = 2'd0;
    v0 = vcnt; e0 = eolcnt; s0 = sofcnt;
    send_frame(3, 2, -1, -1);
    chk_frame(3, 0, v0, e0, s0);
    chk("fcnt_f3", 64'(o_frame_cnt), 64'd3);
    chk("active_stop", 64'(o_active), 64'd0);
    v0 = vcnt;
    send_frame(4, -1, -1, -1);
    chk("vcnt_f4", 64'(vcnt - v0), 64'd0);
    chk("fcnt_f4", 64'(o_frame_cnt), 64'd3);

    // Start mid-frame: partial frame dropped, next frame captured from (0,0).
    v0 = vcnt;
    send_frame(5, -1, 1, -1);
    chk("vcnt_partial", 64'(vcnt - v0), 64'd0);
    chk("fcnt_partial", 64'(o_frame_cnt), 64'd3);
    v0 = vcnt; e0 = eolcnt; s0 = sofcnt;
    send_frame(6, -1, -1, -1);
    chk_frame(6, 0, v0, e0, s0);
    chk("fcnt_f6", 64'(o_frame_cnt), 64'd4);
    i_stop = 1'b1; tick; i_stop = 1'b0; tick;
    chk("active_idle_stop", 64'(o_active), 64'd0);

    // Start and stop together from IDLE.
    i_start = 1'b1; i_stop = 1'b1; tick; i_start = 1'b0; i_stop = 1'b0;
    repeat (2) tick;
    v0 = vcnt;
    send_frame(7, -1, -1, -1);
    chk("vcnt_startstop", 64'(vcnt - v0), 64'd0);
    chk("active_startstop", 64'(o_active), 64'd0);

    // Reset mid-line while capturing.
    i_start = 1'b1; tick; i_start = 1'b0;
    repeat (3) tick;
    send_frame(8, -1, -1, 1);
    v0 = vcnt;
    send_frame(9, -1, -1, -1);
    chk("vcnt_after_rst", 64'(vcnt - v0), 64'd0);
    chk("fcnt_after_rst", 64'(o_frame_cnt), 64'd0);
    i_start = 1'b1; tick; i_start = 1'b0;
    repeat (3) tick;
    v0 = vcnt; e0 = eolcnt; s0 = sofcnt;
    send_frame(10, -1, -1, -1);
    chk_frame(10, 0, v0, e0, s0);
    chk("fcnt_f10", 64'(o_frame_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
